square_wave_period_meter: RTL and testbench

- Receive-side counterpart of the tone generator. Measures a 1-bit square wave in `clk` cycles and reports the high-phase and low-phase lengths, a lock indication and a loss-of-signal flag.
- Used to check generator output and to measure external tone inputs.
- Result units match the generator's `half_wave_period`: a wave produced with `half_wave_period = N` measures N per phase.

---
 rtl/square_wave_period_meter.sv | 88 ++++++++
 tb/tb_square_wave_period_meter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_wave_period_meter.sv
// square_wave_period_meter: measures the high and low phase lengths of a square wave in clk cycles,
// with a period-stability lock indication and loss-of-signal detection.
module square_wave_period_meter #(
    parameter int CNT_WIDTH  = 28,
    parameter int TIMEOUT    = 100_000_000,
    parameter int TOL        = 2,
    parameter int LOCK_COUNT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wave_in,
    output logic [CNT_WIDTH-1:0] high_cycles,
    output logic [CNT_WIDTH-1:0] low_cycles,
    output logic                 meas_valid,
    output logic                 meas_phase,
    output logic                 locked,
    output logic                 no_signal
);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t               state_q;
    logic [2:0]           sync_q;
    logic [CNT_WIDTH-1:0] cnt_q, prev_q, high_q, low_q;
    logic                 prev_vld_q, meas_valid_q, meas_phase_q, locked_q, no_signal_q;
    logic [3:0]           match_q, match_d;
    logic [CNT_WIDTH:0]   diff;
    logic                 edge_det;

    assign edge_det = sync_q[1] ^ sync_q[2];
    // One extra bit so the absolute difference can never wrap.
    assign diff = (cnt_q >= prev_q) ? {1'b0, cnt_q} - {1'b0, prev_q} : {1'b0, prev_q} - {1'b0, cnt_q};
    assign match_d = !(prev_vld_q && diff <= (CNT_WIDTH+1)'(TOL)) ? 4'd0 :
                     (match_q == 4'(LOCK_COUNT)) ? match_q : match_q + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            match_q      <= '0;
            high_q       <= '0;
            low_q        <= '0;
            meas_valid_q <= 1'b0;
            meas_phase_q <= 1'b0;
            locked_q     <= 1'b0;
            no_signal_q  <= 1'b1;
        end else begin
            sync_q       <= {sync_q[1:0], wave_in};
            meas_valid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (edge_det) begin
                    state_q     <= MEASURE;
                    cnt_q       <= CNT_WIDTH'(1);
                    no_signal_q <= 1'b0;
                end
            end else if (edge_det) begin
                cnt_q        <= CNT_WIDTH'(1);
                meas_valid_q <= 1'b1;
                meas_phase_q <= sync_q[2];
                if (sync_q[2]) high_q <= cnt_q;
                else low_q <= cnt_q;
                match_q    <= match_d;
                locked_q   <= (match_d == 4'(LOCK_COUNT));
                prev_q     <= cnt_q;
                prev_vld_q <= 1'b1;
            end else if (cnt_q == CNT_WIDTH'(TIMEOUT)) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                no_signal_q <= 1'b1;
                locked_q    <= 1'b0;
                match_q     <= '0;
                prev_vld_q  <= 1'b0;
                high_q      <= '0;
                low_q       <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign high_cycles = high_q;
    assign low_cycles  = low_q;
    assign meas_valid  = meas_valid_q;
    assign meas_phase  = meas_phase_q;
    assign locked      = locked_q;
    assign no_signal   = no_signal_q;
endmodule

// File: tb/tb_square_wave_period_meter.sv
// tb_square_wave_period_meter: directed tests over four parameterisations of the period meter.
module tb_square_wave_period_meter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wave = 1'b0;
    int   cyc = 0;
    int   sel = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [27:0] hi0, lo0, hi1, lo1, hi2, lo2;
    logic [3:0]  hi3, lo3;
    logic        mv0, ph0, lk0, ns0, mv1, ph1, lk1, ns1, mv2, ph2, lk2, ns2, mv3, ph3, lk3, ns3;
    logic [27:0] m_hi, m_lo;
    logic        m_mv, m_ph, m_lk, m_ns;

    typedef struct {logic ph; int val; logic lk; int cyc;} rec_t;
    rec_t q[$];

    square_wave_period_meter u0 (
        .clk(clk), .reset(reset), .wave_in(wave), .high_cycles(hi0), .low_cycles(lo0),
        .meas_valid(mv0), .meas_phase(ph0), .locked(lk0), .no_signal(ns0));
    square_wave_period_meter #(.TOL(0)) u1 (
        .clk(clk), .reset(reset), .wave_in(wave), .high_cycles(hi1), .low_cycles(lo1),
        .meas_valid(mv1), .meas_phase(ph1), .locked(lk1), .no_signal(ns1));
    square_wave_period_meter #(.TIMEOUT(50)) u2 (
        .clk(clk), .reset(reset), .wave_in(wave), .high_cycles(hi2), .low_cycles(lo2),
        .meas_valid(mv2), .meas_phase(ph2), .locked(lk2), .no_signal(ns2));
    square_wave_period_meter #(.CNT_WIDTH(4), .TIMEOUT(15)) u3 (
        .clk(clk), .reset(reset), .wave_in(wave), .high_cycles(hi3), .low_cycles(lo3),
        .meas_valid(mv3), .meas_phase(ph3), .locked(lk3), .no_signal(ns3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        {m_hi, m_lo, m_mv, m_ph, m_lk, m_ns} = {hi0, lo0, mv0, ph0, lk0, ns0};
        if (sel == 1) {m_hi, m_lo, m_mv, m_ph, m_lk, m_ns} = {hi1, lo1, mv1, ph1, lk1, ns1};
        if (sel == 2) {m_hi, m_lo, m_mv, m_ph, m_lk, m_ns} = {hi2, lo2, mv2, ph2, lk2, ns2};
        if (sel == 3) {m_hi, m_lo, m_mv, m_ph, m_lk, m_ns} = {24'd0, hi3, 24'd0, lo3, mv3, ph3, lk3, ns3};
    end

    // Measurement log of the instance under test, sampled mid-cycle.
    always @(negedge clk)
        if (m_mv) q.push_back('{m_ph, m_ph ? int'(m_hi) : int'(m_lo), m_lk, cyc});

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wave = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        q.delete();
    endtask

    task automatic phases(input int n, input int a, input int b);
        for (int i = 0; i < n; i++) begin
            wave = (i % 2 == 0);
            repeat ((i % 2 == 0) ? a : b) tick();
        end
    endtask

    task automatic test_reset();
        sel = 0;
        reset = 1'b1;
        repeat (2) tick();
        n_chk += 6;
        if (m_hi !== 28'd0) begin n_fail++; $display("FAIL rst_high: got %0d expected 0", m_hi); end
        if (m_lo !== 28'd0) begin n_fail++; $display("FAIL rst_low: got %0d expected 0", m_lo); end
        if (m_mv !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", m_mv); end
        if (m_ph !== 1'b0) begin n_fail++; $display("FAIL rst_phase: got %b expected 0", m_ph); end
        if (m_lk !== 1'b0) begin n_fail++; $display("FAIL rst_locked: got %b expected 0", m_lk); end
        if (m_ns !== 1'b1) begin n_fail++; $display("FAIL rst_nosig: got %b expected 1", m_ns); end
    endtask

    task automatic test_n10();
        int t0;
        sel = 0;
        do_reset();
        t0 = cyc;
        phases(8, 10, 10);
        wave = 1'b1;
        repeat (4) tick();
        n_chk++;
        if (q.size() != 8) begin n_fail++; $display("FAIL n10_count: got %0d expected 8", q.size()); end
        n_chk++;
        if (q.size() > 0 && q[0].cyc != t0 + 13) begin n_fail++; $display("FAIL n10_first: got %0d expected %0d", q[0].cyc, t0 + 13); end
        foreach (q[j]) begin
            n_chk += 3;
            if (q[j].ph !== (j % 2 == 0)) begin n_fail++; $display("FAIL n10_phase[%0d]: got %b expected %b", j, q[j].ph, j % 2 == 0); end
            if (q[j].val != 10) begin n_fail++; $display("FAIL n10_val[%0d]: got %0d expected 10", j, q[j].val); end
            if (q[j].lk !== (j >= 4)) begin n_fail++; $display("FAIL n10_lock[%0d]: got %b expected %b", j, q[j].lk, j >= 4); end
            if (j > 0) begin
                n_chk++;
                if (q[j].cyc - q[j-1].cyc != 10) begin n_fail++; $display("FAIL n10_gap[%0d]: got %0d expected 10", j, q[j].cyc - q[j-1].cyc); end
            end
        end
    endtask

    task automatic test_asym();
        sel = 1;
        do_reset();
        phases(8, 3, 7);
        wave = 1'b1;
        repeat (4) tick();
        n_chk++;
        if (q.size() != 8) begin n_fail++; $display("FAIL asym_count: got %0d expected 8", q.size()); end
        foreach (q[j]) begin
            n_chk += 2;
            if (q[j].val != ((j % 2 == 0) ? 3 : 7)) begin n_fail++; $display("FAIL asym_val[%0d]: got %0d expected %0d", j, q[j].val, (j % 2 == 0) ? 3 : 7); end
            if (q[j].lk !== 1'b0) begin n_fail++; $display("FAIL asym_lock[%0d]: got %b expected 0", j, q[j].lk); end
            if (j > 0) begin
                n_chk++;
                if (q[j].cyc - q[j-1].cyc != ((j % 2 == 0) ? 3 : 7)) begin n_fail++; $display("FAIL asym_gap[%0d]: got %0d expected %0d", j, q[j].cyc - q[j-1].cyc, (j % 2 == 0) ? 3 : 7); end
            end
        end
    endtask

    task automatic test_tolerance();
        sel = 0;
        do_reset();
        phases(8, 10, 12);
        wave = 1'b1;
        repeat (4) tick();
        n_chk++;
        if (q.size() != 8) begin n_fail++; $display("FAIL tol12_count: got %0d expected 8", q.size()); end
        foreach (q[j]) begin
            n_chk += 2;
            if (q[j].val != ((j % 2 == 0) ? 10 : 12)) begin n_fail++; $display("FAIL tol12_val[%0d]: got %0d expected %0d", j, q[j].val, (j % 2 == 0) ? 10 : 12); end
            if (q[j].lk !== (j >= 4)) begin n_fail++; $display("FAIL tol12_lock[%0d]: got %b expected %b", j, q[j].lk, j >= 4); end
        end
        do_reset();
        phases(8, 10, 13);
        wave = 1'b1;
        repeat (4) tick();
        n_chk++;
        if (q.size() != 8) begin n_fail++; $display("FAIL tol13_count: got %0d expected 8", q.size()); end
        foreach (q[j]) begin
            n_chk++;
            if (q[j].lk !== 1'b0) begin n_fail++; $display("FAIL tol13_lock[%0d]: got %b expected 0", j, q[j].lk); end
        end
        do_reset();
        phases(6, 10, 10);
        wave = 1'b1;
        repeat (20) tick();
        for (int i = 0; i < 6; i++) begin
            wave = ~wave;
            repeat (10) tick();
        end
        wave = ~wave;
        repeat (4) tick();
        n_chk++;
        if (q.size() != 13) begin n_fail++; $display("FAIL glitch_count: got %0d expected 13", q.size()); end
        foreach (q[j]) begin
            n_chk += 2;
            if (q[j].val != ((j == 6) ? 20 : 10)) begin n_fail++; $display("FAIL glitch_val[%0d]: got %0d expected %0d", j, q[j].val, (j == 6) ? 20 : 10); end
            if (q[j].lk !== (j == 4 || j == 5 || j >= 11)) begin n_fail++; $display("FAIL glitch_lock[%0d]: got %b expected %b", j, q[j].lk, j == 4 || j == 5 || j >= 11); end
        end
    endtask

    task automatic test_timeout();
        int t0;
        sel = 2;
        do_reset();
        phases(6, 10, 10);
        wave = 1'b1;
        repeat (52) tick();
        n_chk += 3;
        if (q.size() != 6) begin n_fail++; $display("FAIL to_count: got %0d expected 6", q.size()); end
        if (m_ns !== 1'b0) begin n_fail++; $display("FAIL to_early_nosig: got %b expected 0", m_ns); end
        if (m_lk !== 1'b1) begin n_fail++; $display("FAIL to_early_lock: got %b expected 1", m_lk); end
        tick();
        n_chk += 4;
        if (m_ns !== 1'b1) begin n_fail++; $display("FAIL to_nosig: got %b expected 1", m_ns); end
        if (m_lk !== 1'b0) begin n_fail++; $display("FAIL to_lock: got %b expected 0", m_lk); end
        if (m_hi !== 28'd0) begin n_fail++; $display("FAIL to_high: got %0d expected 0", m_hi); end
        if (m_lo !== 28'd0) begin n_fail++; $display("FAIL to_low: got %0d expected 0", m_lo); end
        q.delete();
        t0 = cyc;
        wave = 1'b0;
        repeat (10) tick();
        wave = 1'b1;
        repeat (10) tick();
        wave = 1'b0;
        repeat (4) tick();
        n_chk += 2;
        if (q.size() != 2) begin n_fail++; $display("FAIL resume_count: got %0d expected 2", q.size()); end
        if (m_ns !== 1'b0) begin n_fail++; $display("FAIL resume_nosig: got %b expected 0", m_ns); end
        if (q.size() > 0) begin
            n_chk += 3;
            if (q[0].val != 10) begin n_fail++; $display("FAIL resume_val: got %0d expected 10", q[0].val); end
            if (q[0].ph !== 1'b0) begin n_fail++; $display("FAIL resume_phase: got %b expected 0", q[0].ph); end
            if (q[0].cyc != t0 + 13) begin n_fail++; $display("FAIL resume_time: got %0d expected %0d", q[0].cyc, t0 + 13); end
        end
    endtask

    task automatic test_min();
        sel = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wave = ~wave;
            tick();
        end
        repeat (5) tick();
        n_chk++;
        if (q.size() != 19) begin n_fail++; $display("FAIL min_count: got %0d expected 19", q.size()); end
        foreach (q[j]) begin
            n_chk++;
            if (q[j].val != 1) begin n_fail++; $display("FAIL min_val[%0d]: got %0d expected 1", j, q[j].val); end
            if (j > 0) begin
                n_chk++;
                if (q[j].cyc - q[j-1].cyc != 1) begin n_fail++; $display("FAIL min_gap[%0d]: got %0d expected 1", j, q[j].cyc - q[j-1].cyc); end
            end
        end
    endtask

    task automatic test_saturation();
        sel = 3;
        do_reset();
        wave = 1'b1;
        repeat (15) tick();
        wave = 1'b0;
        repeat (4) tick();
        n_chk += 2;
        if (q.size() != 1) begin n_fail++; $display("FAIL sat15_count: got %0d expected 1", q.size()); end
        if (m_ns !== 1'b0) begin n_fail++; $display("FAIL sat15_nosig: got %b expected 0", m_ns); end
        if (q.size() > 0) begin
            n_chk++;
            if (q[0].val != 15) begin n_fail++; $display("FAIL sat15_val: got %0d expected 15", q[0].val); end
        end
        do_reset();
        wave = 1'b1;
        repeat (16) tick();
        wave = 1'b0;
        repeat (4) tick();
        n_chk += 2;
        if (q.size() != 0) begin n_fail++; $display("FAIL sat16_count: got %0d expected 0", q.size()); end
        if (m_ns !== 1'b0) begin n_fail++; $display("FAIL sat16_rearm: got %b expected 0", m_ns); end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        do_reset();
        phases(6, 10, 10);
        wave = 1'b1;
        repeat (5) tick();
        n_chk++;
        if (m_lk !== 1'b1) begin n_fail++; $display("FAIL mid_prelock: got %b expected 1", m_lk); end
        reset = 1'b1;
        tick();
        n_chk += 6;
        if (m_hi !== 28'd0) begin n_fail++; $display("FAIL mid_high: got %0d expected 0", m_hi); end
        if (m_lo !== 28'd0) begin n_fail++; $display("FAIL mid_low: got %0d expected 0", m_lo); end
        if (m_mv !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b expected 0", m_mv); end
        if (m_ph !== 1'b0) begin n_fail++; $display("FAIL mid_phase: got %b expected 0", m_ph); end
        if (m_lk !== 1'b0) begin n_fail++; $display("FAIL mid_locked: got %b expected 0", m_lk); end
        if (m_ns !== 1'b1) begin n_fail++; $display("FAIL mid_nosig: got %b expected 1", m_ns); end
        reset = 1'b0;
        q.delete();
        repeat (7) tick();
        wave = 1'b0;
        repeat (4) tick();
        n_chk += 2;
        if (q.size() != 1) begin n_fail++; $display("FAIL mid_count: got %0d expected 1", q.size()); end
        if (m_ns !== 1'b0) begin n_fail++; $display("FAIL mid_rearm: got %b expected 0", m_ns); end
        if (q.size() > 0) begin
            n_chk += 2;
            if (q[0].val != 7) begin n_fail++; $display("FAIL mid_val: got %0d expected 7", q[0].val); end
            if (q[0].ph !== 1'b1) begin n_fail++; $display("FAIL mid_meas_phase: got %b expected 1", q[0].ph); end
        end
    endtask

    initial begin
        test_reset();
        test_n10();
        test_asym();
        test_tolerance();
        test_timeout();
        test_min();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
